// File: rtl/uart_pkg.sv
// Shared UART definitions: tx state encoding, baud divider and frame width.
// Used by the transmitter and the oversampling receiver.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    function automatic int baud_div(input int clk_rate, input int baud_rate);
        return (clk_rate + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Host-side byte handshake and line outputs of the UART transmitter.
// master = host/byte source, slave = transmitter.
interface uart_tx_engine_if;
    import uart_pkg::*;

    logic                      TxDataLoad;
    logic [UART_DATA_BITS-1:0] TxDataIn;
    logic                      TxReady;
    logic                      TxDataOut;
    logic                      TxBusy;
    logic                      TxDone;

    modport master (
        output TxDataLoad, TxDataIn,
        input  TxReady, TxDataOut, TxBusy, TxDone
    );

    modport slave (
        input  TxDataLoad, TxDataIn,
        output TxReady, TxDataOut, TxBusy, TxDone
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: one-cycle tick at count Divider-1, synchronous restart.
// Shared between the transmitter and the receiver.
module uart_baud_tick #(
    parameter int Divider = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CntW = $clog2(Divider);
    localparam logic [CntW-1:0] CntMax = CntW'(Divider - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: one-byte holding register feeding a shift FSM,
// bit timing from a clock-enable baud counter.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int ClockRate = 10000000,
    parameter int BaudRate  = 9600,
    parameter int ParityEn  = 0,
    parameter int ParityOdd = 0,
    parameter int StopBits  = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    uart_tx_engine_if.slave tx
);

    localparam int Divider = baud_div(ClockRate, BaudRate);
    localparam int IdxW    = $clog2(UART_DATA_BITS);

    localparam logic [IdxW-1:0] LastIdx  = IdxW'(UART_DATA_BITS - 1);
    localparam logic            LastStop = 1'(StopBits - 1);
    localparam logic            OddBit   = 1'(ParityOdd);

    if (Divider < 2) begin : g_div_chk
        $error("uart_tx_engine: Divider must be at least 2");
    end
    if (StopBits != 1 && StopBits != 2) begin : g_stop_chk
        $error("uart_tx_engine: StopBits must be 1 or 2");
    end

    tx_state_e                 state_q, state_d;
    logic [UART_DATA_BITS-1:0] hold_q, hold_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      hold_valid_q, hold_valid_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic                      stop_q, stop_d;
    logic                      tick;
    logic                      pull;
    logic                      ready;
    logic                      accept;
    logic                      line;
    logic                      done;

    uart_baud_tick #(
        .Divider (Divider)
    ) u_baud_tick (
        .clk_i     (Clock),
        .rst_ni    (Reset),
        .restart_i (state_q == TX_IDLE),
        .tick_o    (tick)
    );

    // A byte offered in the cycle the shifter empties the register is taken.
    assign ready  = !hold_valid_q || pull;
    assign accept = tx.TxDataLoad && ready;

    assign tx.TxReady   = ready;
    assign tx.TxDataOut = line;
    assign tx.TxBusy    = (state_q != TX_IDLE);
    assign tx.TxDone    = done;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        pull    = 1'b0;
        done    = 1'b0;
        line    = 1'b1;
        unique case (state_q)
            TX_IDLE: begin
                if (hold_valid_q) begin
                    pull    = 1'b1;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                line = 1'b0;
                if (tick) begin
                    state_d = TX_DATA;
                    idx_d   = '0;
                end
            end
            TX_DATA: begin
                line = shift_q[idx_q];
                if (tick) begin
                    if (idx_q == LastIdx) begin
                        state_d = (ParityEn != 0) ? TX_PARITY : TX_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            TX_PARITY: begin
                line = (^shift_q) ^ OddBit;
                if (tick) begin
                    state_d = TX_STOP;
                    stop_d  = 1'b0;
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (stop_q == LastStop) begin
                        done = 1'b1;
                        if (hold_valid_q) begin
                            pull    = 1'b1;
                            state_d = TX_START;
                        end else begin
                            state_d = TX_IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase

        hold_d       = accept ? tx.TxDataIn : hold_q;
        hold_valid_d = accept ? 1'b1 : (pull ? 1'b0 : hold_valid_q);
        shift_d      = pull ? hold_q : shift_q;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= TX_IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            idx_q        <= '0;
            stop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            stop_q       <= stop_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed/random bench for uart_tx_engine, three parameter sets at Divider=16.
// Line activity is recorded each cycle and compared with a frame-level model.
module tb_uart_tx_engine;

    localparam int DIV = 16;

    logic       clk;
    logic       rst_n;
    logic [2:0] load_r;
    logic [7:0] din_r [3];
    logic [2:0] ready_w;
    logic [2:0] line_w;
    logic [2:0] busy_w;
    logic [2:0] done_w;

    int checks;
    int failures;

    logic       rec_en;
    logic [2:0] rec [3][$];
    logic [7:0] exp_b [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // g=0: no parity, 1 stop; g=1: even parity, 2 stop; g=2: odd parity, 2 stop
    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_tx_engine_if ifc ();

        assign ifc.TxDataLoad = load_r[g];
        assign ifc.TxDataIn   = din_r[g];
        assign ready_w[g]     = ifc.TxReady;
        assign line_w[g]      = ifc.TxDataOut;
        assign busy_w[g]      = ifc.TxBusy;
        assign done_w[g]      = ifc.TxDone;

        uart_tx_engine #(
            .ClockRate (1600000),
            .BaudRate  (100000),
            .ParityEn  ((g > 0) ? 1 : 0),
            .ParityOdd ((g == 2) ? 1 : 0),
            .StopBits  ((g > 0) ? 2 : 1)
        ) u_dut (
            .Clock (clk),
            .Reset (rst_n),
            .tx    (ifc.slave)
        );
    end

    always @(negedge clk) begin
        if (rec_en) begin
            for (int g = 0; g < 3; g++) begin
                rec[g].push_back({done_w[g], busy_w[g], line_w[g]});
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic rec_start();
        for (int g = 0; g < 3; g++) rec[g].delete();
        rec_en = 1'b1;
    endtask

    // Offer a byte for up to budget edges; acc reports whether it was taken.
    task automatic load_try(input int g, input logic [7:0] b,
                            input int budget, output bit acc);
        acc = 1'b0;
        @(negedge clk);
        load_r[g] = 1'b1;
        din_r[g]  = b;
        for (int i = 0; i < budget && !acc; i++) begin
            acc = ready_w[g];
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        #1;
        load_r[g] = 1'b0;
    endtask

    // Compare the recording of DUT g with the frames of exp_b sent back to back.
    task automatic analyse(input int g, input string tag, input int pen,
                           input int podd, input int nstop, output int s);
        bit bits [$];
        int cyc, total, n, rel, ml, mb, md, dones, fd;
        bit el, eb, ed;
        bits = {};
        foreach (exp_b[k]) begin
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(exp_b[k][i]);
            if (pen != 0) bits.push_back(1'(($countones(exp_b[k]) % 2) ^ podd));
            for (int i = 0; i < nstop; i++) bits.push_back(1'b1);
        end
        cyc   = (9 + pen + nstop) * DIV;
        total = cyc * exp_b.size();
        n     = rec[g].size();
        s     = -1;
        for (int i = 0; i < n; i++) begin
            if (s < 0 && rec[g][i][0] === 1'b0) s = i;
        end
        chk({tag, "_start_seen"}, int'(s >= 0), 1);
        if (s < 0) return;
        chk({tag, "_covered"}, int'(n >= s + total + 1), 1);
        ml = 0; mb = 0; md = 0; dones = 0; fd = -1;
        for (int i = 0; i < n; i++) begin
            rel = i - s;
            el = 1'b1; eb = 1'b0; ed = 1'b0;
            if (rel >= 0 && rel < total) begin
                el = bits[rel / DIV];
                eb = 1'b1;
                ed = ((rel % cyc) == cyc - 1);
            end
            if (rec[g][i][0] !== el) ml++;
            if (rec[g][i][1] !== eb) mb++;
            if (rec[g][i][2] !== ed) md++;
            if (rec[g][i][2] === 1'b1) begin
                dones++;
                if (fd < 0) fd = i;
            end
        end
        chk({tag, "_line_errs"}, ml, 0);
        chk({tag, "_busy_errs"}, mb, 0);
        chk({tag, "_done_errs"}, md, 0);
        chk({tag, "_done_count"}, dones, exp_b.size());
        chk({tag, "_frame_len"}, fd - s + 1, cyc);
    endtask

    initial begin
        bit         acc;
        int         s, act, pbit;
        logic [7:0] ra, rb;

        checks   = 0;
        failures = 0;
        rec_en   = 1'b0;
        load_r   = '0;
        for (int g = 0; g < 3; g++) din_r[g] = '0;

        // Reset
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_line", int'(line_w), 7);
        chk("rst_ready", int'(ready_w), 7);
        chk("rst_busy", int'(busy_w), 0);
        chk("rst_done", int'(done_w), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rec_start();
        repeat (100) @(posedge clk);
        rec_en = 1'b0;
        act = 0;
        for (int g = 0; g < 3; g++) begin
            foreach (rec[g][i]) if (rec[g][i] !== 3'b001) act++;
        end
        chk("rst_idle_activity", act, 0);
        chk("rst_idle_ready", int'(ready_w), 7);

        // Single byte with start latency
        rec_start();
        repeat (3) @(posedge clk);
        load_try(0, 8'hA5, 1, acc);
        chk("single_acc", int'(acc), 1);
        chk("single_line_after_load", int'(line_w[0]), 1);
        chk("single_busy_after_load", int'(busy_w[0]), 0);
        @(posedge clk);
        #1;
        chk("single_line_start", int'(line_w[0]), 0);
        chk("single_busy_start", int'(busy_w[0]), 1);
        repeat (200) @(posedge clk);
        rec_en = 1'b0;
        exp_b = {8'hA5};
        analyse(0, "single", 0, 0, 1, s);

        // Back-to-back with an ignored third load
        rec_start();
        repeat (2) @(posedge clk);
        load_try(0, 8'h00, 1, acc);
        chk("b2b_acc0", int'(acc), 1);
        @(posedge clk);
        load_try(0, 8'hFF, 1, acc);
        chk("b2b_acc1", int'(acc), 1);
        repeat (4) @(posedge clk);
        load_try(0, 8'h55, 1, acc);
        chk("b2b_acc2_ignored", int'(acc), 0);
        repeat (400) @(posedge clk);
        rec_en = 1'b0;
        exp_b = {8'h00, 8'hFF};
        analyse(0, "b2b", 0, 0, 1, s);

        // Parity and two stop bits
        rec_start();
        repeat (2) @(posedge clk);
        load_try(1, 8'h07, 1, acc);
        chk("par_even_acc", int'(acc), 1);
        load_try(2, 8'h07, 1, acc);
        chk("par_odd_acc", int'(acc), 1);
        repeat (250) @(posedge clk);
        rec_en = 1'b0;
        exp_b = {8'h07};
        analyse(1, "par_even", 1, 0, 2, s);
        pbit = (s >= 0 && s + 9 * DIV + 8 < rec[1].size()) ?
               int'(rec[1][s + 9 * DIV + 8][0]) : -1;
        chk("par_even_bit", pbit, 1);
        analyse(2, "par_odd", 1, 1, 2, s);
        pbit = (s >= 0 && s + 9 * DIV + 8 < rec[2].size()) ?
               int'(rec[2][s + 9 * DIV + 8][0]) : -1;
        chk("par_odd_bit", pbit, 0);

        // Reset during data bit 3, with a pending byte that must be dropped
        load_try(0, 8'hC3, 1, acc);
        load_try(0, 8'h99, 1, acc);
        repeat (71) @(posedge clk);
        #1;
        chk("midrst_bit3", int'(line_w[0]), 0);
        chk("midrst_ready_full", int'(ready_w[0]), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_line", int'(line_w[0]), 1);
        chk("midrst_ready", int'(ready_w[0]), 1);
        chk("midrst_busy", int'(busy_w[0]), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rec_start();
        repeat (20) @(posedge clk);
        load_try(0, 8'h3C, 1, acc);
        chk("midrst_acc", int'(acc), 1);
        repeat (200) @(posedge clk);
        rec_en = 1'b0;
        exp_b = {8'h3C};
        analyse(0, "midrst_after", 0, 0, 1, s);

        // Refill in the cycle the shifter empties the register, random bytes
        for (int t = 0; t < 2; t++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rec_start();
            repeat (2) @(posedge clk);
            load_try(0, ra, 1, acc);
            chk("refill_acc_a", int'(acc), 1);
            load_try(0, rb, 400, acc);
            chk("refill_acc_b", int'(acc), 1);
            repeat (400) @(posedge clk);
            rec_en = 1'b0;
            exp_b = {ra, rb};
            analyse(0, "refill", 0, 0, 1, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
